// File: rtl/npu_lsu_arb_if.sv
// Requester-side and memory-side bus of npu_lsu_arb; signal suffixes are relative to the arbiter.
// slave = arbiter view, master = environment view.
interface npu_lsu_arb_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ-1:0]        we_i;
  logic [N_REQ*ADDR_W-1:0] addr_i;
  logic [N_REQ*DATA_W-1:0] wdata_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        rvalid_o;
  logic [DATA_W-1:0]       rdata_o;
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [ADDR_W-1:0]       mem_addr_o;
  logic [DATA_W-1:0]       mem_wdata_o;
  logic                    mem_gnt_i;
  logic                    mem_rvalid_i;
  logic [DATA_W-1:0]       mem_rdata_i;
  logic                    busy_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
  );
  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/npu_lsu_arb.sv
// Single-outstanding arbiter sharing one memory port among N_REQ LSU requesters (IDLE/REQ/WAIT).
// Round-robin by default; define NPU_LSU_ARB_PRIO_EN for fixed priority 2 > 0 > 1 (no pointer).
module npu_lsu_arb #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  npu_lsu_arb_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  function automatic logic [IDX_W-1:0] nxt_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_REQ-1)) ? '0 : idx + IDX_W'(1);
  endfunction

  state_e                       state_q;
  txn_t                         txn_q, txn_d;
  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [N_REQ-1:0][DATA_W-1:0] wdata_v;
  logic                         win_vld;
  logic [IDX_W-1:0]             win_idx;
  logic [N_REQ-1:0]             owner_oh;
  logic                         gnt_fire, rsp_fire, mem_act;

  assign addr_v  = bus.addr_i;
  assign wdata_v = bus.wdata_i;

`ifdef NPU_LSU_ARB_PRIO_EN
  // Write-back drains first so the MAC output never stalls behind loads.
  always_comb begin
    win_vld = |bus.req_i;
    win_idx = '0;
    if (bus.req_i[2])      win_idx = IDX_W'(2);
    else if (bus.req_i[0]) win_idx = IDX_W'(0);
    else if (bus.req_i[1]) win_idx = IDX_W'(1);
  end
`else
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] scan;

  // First requester found walking ptr, ptr+1, ... with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_vld && bus.req_i[scan]) begin
        win_vld = 1'b1;
        win_idx = scan;
      end
      scan = nxt_idx(scan);
    end
  end
`endif

  always_comb begin
    txn_d       = txn_q;
    txn_d.owner = win_idx;
    txn_d.we    = bus.we_i[win_idx];
    txn_d.addr  = addr_v[win_idx];
    txn_d.wdata = wdata_v[win_idx];
  end

  assign gnt_fire = (state_q == REQ)  && bus.mem_gnt_i;
  assign rsp_fire = (state_q == WAIT) && bus.mem_rvalid_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      txn_q   <= '0;
`ifndef NPU_LSU_ARB_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (win_vld) begin
          txn_q   <= txn_d;
          state_q <= REQ;
        end
        REQ: if (gnt_fire) begin
          state_q <= WAIT;
`ifndef NPU_LSU_ARB_PRIO_EN
          ptr_q   <= nxt_idx(txn_q.owner);
`endif
        end
        WAIT: if (rsp_fire) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign owner_oh = N_REQ'(1) << txn_q.owner;
  assign mem_act  = (state_q == REQ);

  assign bus.gnt_o       = gnt_fire ? owner_oh : '0;
  assign bus.rvalid_o    = rsp_fire ? owner_oh : '0;
  assign bus.rdata_o     = rsp_fire ? bus.mem_rdata_i : '0;
  assign bus.mem_req_o   = mem_act;
  assign bus.mem_we_o    = mem_act & txn_q.we;
  assign bus.mem_addr_o  = mem_act ? txn_q.addr : '0;
  assign bus.mem_wdata_o = mem_act ? txn_q.wdata : '0;
  assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_npu_lsu_arb.sv
// Self-checking bench for npu_lsu_arb: vector table, hand sequences, randomized run vs. arbitration model.
module tb_npu_lsu_arb;
  logic clk_i = 1'b0;
  logic arstn_i = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_own;

  npu_lsu_arb_if #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) bus ();

  npu_lsu_arb #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    int          rvw;
    int          own;
    logic        ewe;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference arbitration: the pending requester nearest after the last owner,
  // or the fixed 2 > 0 > 1 ranking in the priority build.
  function automatic int pick(input logic [2:0] pend, input int last);
    int best, bestd, d;
    best = -1;
`ifdef NPU_LSU_ARB_PRIO_EN
    if (pend[2]) best = 2;
    else if (pend[0]) best = 0;
    else if (pend[1]) best = 1;
`else
    bestd = 99;
    for (int i = 0; i < 3; i++) begin
      d = (i - last - 1 + 6) % 3;
      if (pend[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
`endif
    return best;
  endfunction

  task automatic check_quiet(input string nm);
    check({nm, " gnt"},    bus.gnt_o, 0);
    check({nm, " rvalid"}, bus.rvalid_o, 0);
    check({nm, " rdata"},  bus.rdata_o, 0);
    check({nm, " mreq"},   bus.mem_req_o, 0);
    check({nm, " mwe"},    bus.mem_we_o, 0);
    check({nm, " maddr"},  bus.mem_addr_o, 0);
    check({nm, " mwdata"}, bus.mem_wdata_o, 0);
    check({nm, " busy"},   bus.busy_o, 0);
  endtask

  // One full transaction starting in IDLE; own/ew/ea/ed are the expected winner and payload.
  task automatic run_txn(input string nm, input logic [2:0] req, input logic [2:0] we,
                         input logic [95:0] addr, input logic [95:0] wdata,
                         input int stall, input int rvw, input logic [31:0] rd, input bit mut,
                         input int own, input logic ew, input logic [31:0] ea, input logic [31:0] ed);
    logic [2:0] oh;
    oh = 3'b001 << own;
    bus.req_i = req; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wdata;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    #1;
    check({nm, " idle busy"}, bus.busy_o, 0);
    check({nm, " idle mreq"}, bus.mem_req_o, 0);
    step();
    check({nm, " mreq"},   bus.mem_req_o, 1);
    check({nm, " mwe"},    bus.mem_we_o, ew);
    check({nm, " maddr"},  bus.mem_addr_o, ea);
    check({nm, " mwdata"}, bus.mem_wdata_o, ed);
    for (int s = 0; s < stall; s++) begin
      bus.mem_rvalid_i = 1'($urandom_range(0, 1));
      bus.mem_rdata_i  = $urandom();
      if (mut) bus.addr_i[own*32 +: 32] = ea + 32'd4;
      #1;
      check({nm, " stall gnt"},    bus.gnt_o, 0);
      check({nm, " stall rvalid"}, bus.rvalid_o, 0);
      check({nm, " stall rdata"},  bus.rdata_o, 0);
      check({nm, " stall mreq"},   bus.mem_req_o, 1);
      check({nm, " stall maddr"},  bus.mem_addr_o, ea);
      step();
    end
    bus.mem_rvalid_i = 1'b0;
    bus.mem_gnt_i = 1'b1;
    #1;
    check({nm, " gnt"}, bus.gnt_o, oh);
    step();
    bus.mem_gnt_i = 1'b0;
    bus.req_i[own] = 1'b0;
    for (int w = 0; w < rvw; w++) begin
      bus.mem_gnt_i   = 1'($urandom_range(0, 1));
      bus.mem_rdata_i = $urandom();
      #1;
      check({nm, " wait gnt"},    bus.gnt_o, 0);
      check({nm, " wait rvalid"}, bus.rvalid_o, 0);
      check({nm, " wait rdata"},  bus.rdata_o, 0);
      check({nm, " wait mreq"},   bus.mem_req_o, 0);
      check({nm, " wait busy"},   bus.busy_o, 1);
      step();
    end
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i = rd;
    #1;
    check({nm, " rvalid"}, bus.rvalid_o, oh);
    check({nm, " rdata"},  bus.rdata_o, rd);
    step();
    bus.mem_rvalid_i = 1'b0;
    #1;
    check({nm, " done busy"}, bus.busy_o, 0);
  endtask

  initial begin
    vec_t        tbl[4];
    logic [95:0] av, dv;
    logic [2:0]  pend, wev;
    int          own, bud[3], expo[4], ord[$], rise[$];
    logic        prev;

    bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    tbl[0] = '{3'b001, 3'b000, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1, 0, 0, 1'b0};
    tbl[1] = '{3'b100, 3'b100, 32'h0000_0200, 32'h0000_0055, 32'h0,         0, 0, 2, 1'b1};
    tbl[2] = '{3'b010, 3'b000, 32'hFFFF_FFFC, 32'h0,         32'h1234_5678, 2, 1, 1, 1'b0};
    tbl[3] = '{3'b100, 3'b100, 32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 1, 3, 2, 1'b1};

    // Reset state
    step(); step();
    check_quiet("reset");
    arstn_i = 1'b1;
    last_own = 2;
    step();
    check_quiet("post-reset");

    // Vector table: junk in the non-requesting slots must not leak through
    for (int k = 0; k < 4; k++) begin
      av = {$urandom(), $urandom(), $urandom()};
      dv = {$urandom(), $urandom(), $urandom()};
      av[tbl[k].own*32 +: 32] = tbl[k].addr;
      dv[tbl[k].own*32 +: 32] = tbl[k].wdata;
      run_txn($sformatf("vec%0d", k), tbl[k].req, tbl[k].we, av, dv, tbl[k].stall, tbl[k].rvw,
              tbl[k].rdata, 1'b0, tbl[k].own, tbl[k].ewe, tbl[k].addr, tbl[k].wdata);
      last_own = tbl[k].own;
    end

    // Long stall with the requester's address moving underneath
    av = '0; av[31:0] = 32'h100;
    run_txn("stall", 3'b001, 3'b000, av, '0, 10, 0, 32'h0BAD_F00D, 1'b1, 0, 1'b0, 32'h100, 32'h0);
    last_own = 0;

    // Contention: requesters hold req while budget remains
    arstn_i = 1'b0; step(); arstn_i = 1'b1; step();
`ifdef NPU_LSU_ARB_PRIO_EN
    bud = '{1, 1, 2}; expo = '{2, 2, 0, 1};
`else
    bud = '{2, 1, 1}; expo = '{0, 1, 2, 0};
`endif
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; prev = 1'b0;
    for (int c = 0; c < 60 && ord.size() < 4; c++) begin
      for (int i = 0; i < 3; i++) bus.req_i[i] = (bud[i] > 0);
      #1;
      if (bus.mem_req_o && !prev) rise.push_back(c);
      prev = bus.mem_req_o;
      for (int i = 0; i < 3; i++)
        if (bus.gnt_o[i]) begin ord.push_back(i); bud[i]--; end
      step();
    end
    bus.req_i = '0; bus.mem_gnt_i = 1'b0;
    step();
    bus.mem_rvalid_i = 1'b0;
    step();
    check("cont grants", ord.size(), 4);
    for (int k = 0; k < ord.size(); k++) check($sformatf("cont order%0d", k), ord[k], expo[k]);
    for (int k = 1; k < rise.size(); k++) check($sformatf("cont spacing%0d", k), (rise[k] - rise[k-1]) >= 3, 1);
    check("cont busy", bus.busy_o, 0);

    // Reset while waiting for the response; late rvalid must vanish
    bus.req_i = 3'b010; bus.we_i = '0; bus.addr_i = '0; bus.addr_i[63:32] = 32'h300;
    step();
    check("rstw mreq", bus.mem_req_o, 1);
    bus.mem_gnt_i = 1'b1;
    #1;
    check("rstw gnt", bus.gnt_o, 3'b010);
    step();
    bus.mem_gnt_i = 1'b0; bus.req_i = '0;
    check("rstw busy", bus.busy_o, 1);
    arstn_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hABCD_1234;
    #1;
    check_quiet("rstw in reset");
    step();
    arstn_i = 1'b1;
    step();
    check_quiet("rstw late rvalid");
    bus.mem_rvalid_i = 1'b0;
    last_own = 2;
    // Pointer back at 0: with 1 and 2 requesting, round-robin picks 1
    own = pick(3'b110, last_own);
    av = {32'h2222_0000, 32'h1111_0000, 32'h0};
    run_txn("rstw ptr", 3'b110, 3'b000, av, '0, 0, 0, 32'h77, 1'b0, own, 1'b0, av[own*32 +: 32], 32'h0);
    last_own = own;
    pend = 3'b110; pend[own] = 1'b0;
    wev = '0; dv = '0;

    // Randomized traffic vs. the arbitration model
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          wev[i]  = 1'($urandom_range(0, 1));
          av[i*32 +: 32] = $urandom();
          dv[i*32 +: 32] = $urandom();
        end else if (pend[i] && $urandom_range(0, 7) == 0) begin
          pend[i] = 1'b0;
        end
      end
      if (pend == 3'b000) pend[$urandom_range(0, 2)] = 1'b1;
      own = pick(pend, last_own);
      run_txn($sformatf("rnd%0d", t), pend, wev, av, dv, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom(), 1'b0, own, wev[own], av[own*32 +: 32], dv[own*32 +: 32]);
      pend[own] = 1'b0;
      last_own = own;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
